// File: rtl/hazard_scoreboard_ctrl.sv
// hazard_scoreboard_ctrl
// Hazard and forwarding controller for the in-order pipeline. A shadow pipeline
// of NSTAGE entries follows the destination registers of in-flight instructions.
// A busy counter tracks a single multi-cycle unit. The block produces the IF/ID
// stall, the taken-branch flush, the per-operand forwarding selects and the
// multi-cycle completion pulse.
// Optional build macro: HAZ_PERF_EN adds saturating 32-bit perf_stall and
// perf_flush event counters.
module hazard_scoreboard_ctrl #(
    parameter int REG_AW    = 5,
    parameter int NSTAGE    = 3,
    parameter int MC_LAT    = 4,
    parameter int FLUSH_CYC = 1,
    localparam int FW       = $clog2(NSTAGE + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wreg,
    input  logic              id_load,
    input  logic              id_mc,
    input  logic              id_branch,
    input  logic              br_taken,
    output logic              stall,
    output logic              issue,
    output logic              flush,
    output logic [FW-1:0]     fwd_a,
    output logic [FW-1:0]     fwd_b,
    output logic              mc_busy,
    output logic              mc_done,
    output logic [REG_AW-1:0] mc_rd
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0]       perf_stall,
    output logic [31:0]       perf_flush
`endif
);

    localparam int MCW = $clog2(MC_LAT + 1);
    localparam int FCW = $clog2(FLUSH_CYC + 1);

    // Shadow pipeline: index k is post-ID stage k (1 = EXE).
    logic [NSTAGE:1]              sh_vld_q,  sh_vld_d;
    logic [NSTAGE:1]              sh_wreg_q, sh_wreg_d;
    logic [NSTAGE:1]              sh_load_q, sh_load_d;
    logic [NSTAGE:1][REG_AW-1:0]  sh_rd_q,   sh_rd_d;

    logic [MCW-1:0]    mc_cnt_q,   mc_cnt_d;
    logic [REG_AW-1:0] mc_rd_q,    mc_rd_d;
    logic [FCW-1:0]    flush_cnt_q, flush_cnt_d;

    logic [NSTAGE:1] m_rs1, m_rs2;
    logic            squash;
    logic            haz_load, haz_br, haz_mc;
    logic            rs1_mc, rs2_mc, waw_mc;
    logic            br_flush;

    // Per-stage source matches; register 0 and unused sources never match.
    always_comb begin
        m_rs1 = '0;
        m_rs2 = '0;
        for (int k = 1; k <= NSTAGE; k++) begin
            m_rs1[k] = id_rs1_used && (id_rs1 != '0) && sh_vld_q[k] &&
                       sh_wreg_q[k] && (sh_rd_q[k] == id_rs1);
            m_rs2[k] = id_rs2_used && (id_rs2 != '0) && sh_vld_q[k] &&
                       sh_wreg_q[k] && (sh_rd_q[k] == id_rs2);
        end
    end

    // Forwarding select: nearest matching stage wins, so scan from the far end.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = NSTAGE; k >= 1; k--) begin
            if (m_rs1[k]) fwd_a = FW'(k);
            if (m_rs2[k]) fwd_b = FW'(k);
        end
    end

    // Stall / issue / flush decode. Squash overrides everything in ID; an
    // instruction cannot advance while reset is held.
    always_comb begin
        mc_busy  = (mc_cnt_q != '0);
        mc_done  = (mc_cnt_q == MCW'(1));
        squash   = (flush_cnt_q != '0);
        haz_load = (m_rs1[1] | m_rs2[1]) & sh_load_q[1];
        haz_br   = id_branch & (m_rs1[1] | m_rs2[1]);
        // Register 0 is never a hazard, including against the mc destination.
        rs1_mc   = id_rs1_used && (id_rs1 != '0) && (id_rs1 == mc_rd_q);
        rs2_mc   = id_rs2_used && (id_rs2 != '0) && (id_rs2 == mc_rd_q);
        waw_mc   = id_wreg && (id_rd != '0) && (id_rd == mc_rd_q);
        // id_mc while busy covers the structural conflict, incl. the mc_done cycle.
        haz_mc   = mc_busy & (rs1_mc | rs2_mc | waw_mc | id_mc);
        stall    = id_valid & ~squash & (haz_load | haz_br | haz_mc);
        issue    = rst_n & id_valid & ~stall & ~squash;
        br_flush = issue & id_branch & br_taken;
        flush    = br_flush | squash;
    end

    // Next state for the shadow pipeline, mc unit and flush counter.
    always_comb begin
        sh_vld_d     = '0;
        sh_wreg_d    = '0;
        sh_load_d    = '0;
        sh_rd_d      = '0;
        sh_vld_d[1]  = issue;
        // mc results bypass the shadow pipeline: they are never forwarded.
        sh_wreg_d[1] = issue & id_wreg & ~id_mc;
        sh_load_d[1] = issue & id_load;
        sh_rd_d[1]   = issue ? id_rd : '0;
        for (int k = 2; k <= NSTAGE; k++) begin
            sh_vld_d[k]  = sh_vld_q[k-1];
            sh_wreg_d[k] = sh_wreg_q[k-1];
            sh_load_d[k] = sh_load_q[k-1];
            sh_rd_d[k]   = sh_rd_q[k-1];
        end

        mc_cnt_d = mc_cnt_q;
        mc_rd_d  = mc_rd_q;
        if (issue && id_mc) begin
            mc_cnt_d = MCW'(MC_LAT);
            mc_rd_d  = id_rd;
        end else if (mc_busy) begin
            mc_cnt_d = mc_cnt_q - MCW'(1);
            if (mc_done) mc_rd_d = '0;
        end

        flush_cnt_d = flush_cnt_q;
        if (br_flush) begin
            flush_cnt_d = FCW'(FLUSH_CYC - 1);
        end else if (squash) begin
            flush_cnt_d = flush_cnt_q - FCW'(1);
        end
    end

    // Control state: valid bits and counters, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_vld_q    <= '0;
            mc_cnt_q    <= '0;
            mc_rd_q     <= '0;
            flush_cnt_q <= '0;
        end else begin
            sh_vld_q    <= sh_vld_d;
            mc_cnt_q    <= mc_cnt_d;
            mc_rd_q     <= mc_rd_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Shadow payload: only meaningful under sh_vld_q, so it carries no reset.
    always_ff @(posedge clk) begin
        sh_wreg_q <= sh_wreg_d;
        sh_load_q <= sh_load_d;
        sh_rd_q   <= sh_rd_d;
    end

    assign mc_rd = mc_rd_q;

`ifdef HAZ_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    // Saturating event counters.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (stall && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
        if (flush && (perf_flush_q != '1)) perf_flush_d = perf_flush_q + 32'd1;
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall = perf_stall_q;
    assign perf_flush = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Self-checking bench for hazard_scoreboard_ctrl (NSTAGE=3, MC_LAT=4,
// FLUSH_CYC=2). Expected outputs are queued as each cycle's stimulus is
// driven and popped/compared on the following falling edge.
module tb_hazard_scoreboard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_rs1_used, id_rs2_used;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_wreg, id_load, id_mc, id_branch, br_taken;
    logic       stall, issue, flush, mc_busy, mc_done;
    logic [1:0] fwd_a, fwd_b;
    logic [4:0] mc_rd;
`ifdef HAZ_PERF_EN
    logic [31:0] perf_stall, perf_flush;
`endif

    typedef struct packed {
        logic       stall;
        logic       issue;
        logic       flush;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       busy;
        logic       done;
        logic [4:0] mrd;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    hazard_scoreboard_ctrl #(
        .REG_AW(5), .NSTAGE(3), .MC_LAT(4), .FLUSH_CYC(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_wreg(id_wreg), .id_load(id_load), .id_mc(id_mc),
        .id_branch(id_branch), .br_taken(br_taken),
        .stall(stall), .issue(issue), .flush(flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mc_busy(mc_busy), .mc_done(mc_done), .mc_rd(mc_rd)
`ifdef HAZ_PERF_EN
        , .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input int obs, input int expv);
        n_chk++;
        if (obs == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    endtask

    function automatic exp_t mk(input logic st, input logic is, input logic fl,
                                input logic [1:0] fa, input logic [1:0] fb,
                                input logic bz, input logic dn, input logic [4:0] mrd);
        exp_t e;
        e.stall = st; e.issue = is; e.flush = fl; e.fa = fa; e.fb = fb;
        e.busy = bz; e.done = dn; e.mrd = mrd;
        return e;
    endfunction

    task automatic drv(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic w, input logic ld, input logic mc,
                       input logic br, input logic tk);
        id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd; id_wreg = w; id_load = ld; id_mc = mc; id_branch = br; br_taken = tk;
    endtask

    // Pop the oldest expectation and compare every output field against it.
    task automatic sample(input string tag);
        exp_t e;
        chk({tag, ".sb"}, exp_q.size(), 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk({tag, ".stall"}, int'(stall),   int'(e.stall));
        chk({tag, ".issue"}, int'(issue),   int'(e.issue));
        chk({tag, ".flush"}, int'(flush),   int'(e.flush));
        chk({tag, ".fwd_a"}, int'(fwd_a),   int'(e.fa));
        chk({tag, ".fwd_b"}, int'(fwd_b),   int'(e.fb));
        chk({tag, ".busy"},  int'(mc_busy), int'(e.busy));
        chk({tag, ".done"},  int'(mc_done), int'(e.done));
        chk({tag, ".mc_rd"}, int'(mc_rd),   int'(e.mrd));
    endtask

    // One cycle: drive after the rising edge, check on the falling edge.
    task automatic step(input string tag, input logic v, input logic [4:0] rs1,
                        input logic u1, input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic w, input logic ld,
                        input logic mc, input logic br, input logic tk, input exp_t e);
        drv(v, rs1, u1, rs2, u2, rd, w, ld, mc, br, tk);
        exp_q.push_back(e);
        @(negedge clk);
        sample(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input exp_t e);
        step(tag, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e);
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++) idle("idle", mk(0,0,0,0,0,0,0,0));
    endtask

    initial begin
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(mk(0,0,0,0,0,0,0,0));
        @(negedge clk);
        sample("reset");
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Forwarding from EXE, MEM and WB.
        step("add_r3",   1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0, 0, mk(0,1,0,0,0,0,0,0));
        step("fwd_exe",  1, 5'd3, 1, 5'd1, 1, 5'd4, 1, 0, 0, 0, 0, mk(0,1,0,1,0,0,0,0));
        step("fwd_mem",  1, 5'd3, 1, 5'd4, 1, 5'd8, 1, 0, 0, 0, 0, mk(0,1,0,2,1,0,0,0));
        step("fwd_wb",   1, 5'd3, 1, 5'd8, 1, 5'd0, 0, 0, 0, 0, 0, mk(0,1,0,3,1,0,0,0));
        bubbles(3);

        // Load-use: one stall, then forward from MEM.
        step("lw_r5",    1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 0, mk(0,1,0,0,0,0,0,0));
        step("ld_use",   1, 5'd5, 1, 5'd2, 1, 5'd6, 1, 0, 0, 0, 0, mk(1,0,0,1,0,0,0,0));
        step("ld_fwd",   1, 5'd5, 1, 5'd2, 1, 5'd6, 1, 0, 0, 0, 0, mk(0,1,0,2,0,0,0,0));
        bubbles(3);

        // Branches: not taken, then taken behind a dependent ALU op.
        step("br_nt",    1, 5'd1, 1, 5'd2, 1, 5'd0, 0, 0, 0, 1, 0, mk(0,1,0,0,0,0,0,0));
        step("add_r7",   1, 5'd1, 1, 5'd2, 1, 5'd7, 1, 0, 0, 0, 0, mk(0,1,0,0,0,0,0,0));
        step("br_stall", 1, 5'd7, 1, 5'd1, 1, 5'd0, 0, 0, 0, 1, 1, mk(1,0,0,1,0,0,0,0));
        step("br_take",  1, 5'd7, 1, 5'd1, 1, 5'd0, 0, 0, 0, 1, 1, mk(0,1,1,2,0,0,0,0));
        step("squash",   1, 5'd1, 1, 5'd2, 1, 5'd10, 1, 0, 0, 0, 0, mk(0,0,1,0,0,0,0,0));
        step("post_sq",  1, 5'd1, 1, 5'd2, 1, 5'd10, 1, 0, 0, 0, 0, mk(0,1,0,0,0,0,0,0));
        bubbles(3);

        // Multi-cycle op then a dependent reader.
        step("mul_r9",   1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0, 1, 0, 0, mk(0,1,0,0,0,0,0,0));
        step("mc_raw1",  1, 5'd9, 1, 5'd1, 1, 5'd11, 1, 0, 0, 0, 0, mk(1,0,0,0,0,1,0,9));
        step("mc_raw2",  1, 5'd9, 1, 5'd1, 1, 5'd11, 1, 0, 0, 0, 0, mk(1,0,0,0,0,1,0,9));
        step("mc_raw3",  1, 5'd9, 1, 5'd1, 1, 5'd11, 1, 0, 0, 0, 0, mk(1,0,0,0,0,1,0,9));
        step("mc_done",  1, 5'd9, 1, 5'd1, 1, 5'd11, 1, 0, 0, 0, 0, mk(1,0,0,0,0,1,1,9));
        step("mc_after", 1, 5'd9, 1, 5'd1, 1, 5'd11, 1, 0, 0, 0, 0, mk(0,1,0,0,0,0,0,0));
        bubbles(3);

        // Back-to-back multi-cycle ops.
        step("mul_r12",  1, 5'd1, 1, 5'd2, 1, 5'd12, 1, 0, 1, 0, 0, mk(0,1,0,0,0,0,0,0));
        step("mc2_st1",  1, 5'd3, 1, 5'd4, 1, 5'd13, 1, 0, 1, 0, 0, mk(1,0,0,0,0,1,0,12));
        step("mc2_st2",  1, 5'd3, 1, 5'd4, 1, 5'd13, 1, 0, 1, 0, 0, mk(1,0,0,0,0,1,0,12));
        step("mc2_st3",  1, 5'd3, 1, 5'd4, 1, 5'd13, 1, 0, 1, 0, 0, mk(1,0,0,0,0,1,0,12));
        step("mc2_done", 1, 5'd3, 1, 5'd4, 1, 5'd13, 1, 0, 1, 0, 0, mk(1,0,0,0,0,1,1,12));
        step("mc2_iss",  1, 5'd3, 1, 5'd4, 1, 5'd13, 1, 0, 1, 0, 0, mk(0,1,0,0,0,0,0,0));
        idle("mc2_b1", mk(0,0,0,0,0,1,0,13));
        idle("mc2_b2", mk(0,0,0,0,0,1,0,13));
        idle("mc2_b3", mk(0,0,0,0,0,1,0,13));
        idle("mc2_b4", mk(0,0,0,0,0,1,1,13));
        idle("mc2_b5", mk(0,0,0,0,0,0,0,0));

        // Register 0 never forwards or stalls.
        step("wr_r0",    1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 1, 0, 0, 0, mk(0,1,0,0,0,0,0,0));
        step("rd_r0",    1, 5'd0, 1, 5'd0, 1, 5'd14, 1, 0, 0, 0, 0, mk(0,1,0,0,0,0,0,0));
        bubbles(3);

        // Asynchronous reset in the middle of an mc stall.
        step("rst_mul",  1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0, 1, 0, 0, mk(0,1,0,0,0,0,0,0));
        drv(1, 5'd9, 1, 5'd1, 1, 5'd11, 1, 0, 0, 0, 0);
        exp_q.push_back(mk(1,0,0,0,0,1,0,9));
        @(negedge clk);
        sample("rst_pre");
        #2 rst_n = 1'b0;
        #1;
        exp_q.push_back(mk(0,0,0,0,0,0,0,0));
        sample("rst_async");
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("rst_post", 1, 5'd9, 1, 5'd1, 1, 5'd11, 1, 0, 0, 0, 0, mk(0,1,0,0,0,0,0,0));
        bubbles(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
